// File: rtl/puf_response_builder.sv
// puf_response_builder: sequences ring-oscillator PUF measurements and compares RO pairs into a response word
//
// Ports:
//   clk            system clock (also the PUF reference counter clock)
//   RST            asynchronous active-low reset
//   START          one-cycle request to build a response, accepted only in IDLE
//   SEED_CHAL      base {sel, bx} challenge, latched on an accepted START
//   PUF_CHALLENGE  {muxSel, sel, bx} presented to the PUF
//   PUF_EN         PUF measurement enable
//   PUF_RST        active-high PUF counter reset
//   PUF_DONE       PUF measurement-complete flag (only looked at in MEAS)
//   PUF_COUNT      PUF oscillation count
//   BUSY           high from accepted START until FIN
//   VALID          RESPONSE holds a complete result
//   RESPONSE       response word, bit i from measurement pair i
//   TIE_SEEN       sticky: a pair compared equal during this run
//   TIMEOUT_ERR    sticky: a measurement exceeded MAX_WAIT and the run was aborted
module puf_response_builder #(
    parameter int          N_BITS   = 8,
    parameter int          COUNT_W  = 33,
    parameter logic [31:0] MAX_WAIT = 32'h0300_0000
) (
    input  logic               clk,
    input  logic               RST,
    input  logic               START,
    input  logic [5:0]         SEED_CHAL,
    output logic [7:0]         PUF_CHALLENGE,
    output logic               PUF_EN,
    output logic               PUF_RST,
    input  logic               PUF_DONE,
    input  logic [COUNT_W-1:0] PUF_COUNT,
    output logic               BUSY,
    output logic               VALID,
    output logic [N_BITS-1:0]  RESPONSE,
    output logic               TIE_SEEN,
    output logic               TIMEOUT_ERR
);
    typedef enum logic [2:0] {IDLE, CLR, SETTLE, MEAS, CAPT, CMP, FIN} state_t;

    state_t             state, state_n;
    logic [5:0]         seed, seed_n, idx, idx_n;
    logic               m, m_n, settle_cnt, last, timeout;
    logic [31:0]        wait_cnt;
    logic [COUNT_W-1:0] cnt_a, cnt_b;

    assign last    = idx == 6'(N_BITS - 1);
    // DONE wins over the timeout when both land on the final allowed cycle
    assign timeout = state == MEAS && !PUF_DONE && wait_cnt == MAX_WAIT - 32'd1;

    always_comb begin
        state_n = state;
        idx_n   = idx;
        m_n     = m;
        seed_n  = seed;
        case (state)
            IDLE:   if (START) begin
                        state_n = CLR;
                        idx_n   = '0;
                        m_n     = 1'b0;
                        seed_n  = SEED_CHAL;
                    end
            CLR:    state_n = SETTLE;
            SETTLE: state_n = settle_cnt ? MEAS : SETTLE;
            MEAS:   state_n = PUF_DONE ? CAPT : timeout ? FIN : MEAS;
            CAPT:   begin
                        state_n = m ? CMP : CLR;
                        m_n     = 1'b1;
                    end
            CMP:    if (!last) begin
                        state_n = CLR;
                        idx_n   = idx + 6'd1;
                        m_n     = 1'b0;
                    end else begin
                        state_n = FIN;
                    end
            FIN:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe
    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state         <= IDLE;
            seed          <= '0;
            idx           <= '0;
            m             <= 1'b0;
            settle_cnt    <= 1'b0;
            wait_cnt      <= '0;
            cnt_a         <= '0;
            cnt_b         <= '0;
            PUF_CHALLENGE <= '0;
            PUF_EN        <= 1'b0;
            PUF_RST       <= 1'b0;
            BUSY          <= 1'b0;
            VALID         <= 1'b0;
            RESPONSE      <= '0;
            TIE_SEEN      <= 1'b0;
            TIMEOUT_ERR   <= 1'b0;
        end else begin
            state      <= state_n;
            seed       <= seed_n;
            idx        <= idx_n;
            m          <= m_n;
            settle_cnt <= state == SETTLE ? ~settle_cnt : 1'b0;
            wait_cnt   <= state == MEAS ? wait_cnt + 32'd1 : '0;
            if (state == IDLE && START) begin
                RESPONSE    <= '0;
                VALID       <= 1'b0;
                TIE_SEEN    <= 1'b0;
                TIMEOUT_ERR <= 1'b0;
            end
            if (state == CAPT && !m)
                cnt_a <= PUF_COUNT;
            if (state == CAPT && m)
                cnt_b <= PUF_COUNT;
            if (state == CMP) begin
                RESPONSE <= RESPONSE | (N_BITS'(cnt_a > cnt_b) << idx);
                if (cnt_a == cnt_b)
                    TIE_SEEN <= 1'b1;
            end
            if (timeout)
                TIMEOUT_ERR <= 1'b1;
            if (state_n == FIN)
                VALID <= !(timeout || TIMEOUT_ERR);
            // CLR is only ever entered for one cycle, so this is the load on entry
            if (state_n == CLR)
                PUF_CHALLENGE <= {idx_n[0], m_n, seed_n + idx_n};
            PUF_EN  <= state_n == MEAS;
            PUF_RST <= state_n == CLR;
            BUSY    <= state_n inside {CLR, SETTLE, MEAS, CAPT, CMP};
        end
    end
endmodule

// File: doc/puf_response_builder.md
# puf_response_builder

Sequencer and comparator that sits directly downstream of the configurable ring-oscillator PUF. It programs the PUF challenge, pulses the PUF's counter reset, enables a measurement, waits for the PUF's DONE, and captures the 33-bit oscillation count. Counts from RO pairs are compared to build an N_BITS-wide response word that is handed to the key/ID logic.

## Interface
- N_BITS, 8: number of response bits produced per START (1..64).
- COUNT_W, 33: width of the PUF count input.
- MAX_WAIT, 32'h0300_0000: clk cycles allowed in MEAS before timeout; must exceed the PUF's DONE threshold.
- clk  in  1  system clock; also drives the PUF's reference counter.
- RST  in  1  asynchronous, active-low reset (0 = reset).
- START  in  1  single-cycle request to build a response; sampled only in IDLE.
- SEED_CHAL  in  6  base {sel[2:0], bx[2:0]} challenge, latched on accepted START.
- PUF_CHALLENGE  out  8  {muxSel[1:0], sel[2:0], bx[2:0]} to PUF.
- PUF_EN  out  1  PUF enable.
- PUF_RST  out  1  active-high counter reset to PUF.
- PUF_DONE  in  1  PUF measurement-complete flag.
- PUF_COUNT  in  COUNT_W  PUF oscillation count.
- BUSY  out  1  high from accepted START until FIN.
- VALID  out  1  RESPONSE holds a complete result.
- RESPONSE  out  N_BITS  response word; bit i from measurement pair i.
- TIE_SEEN  out  1  sticky: at least one pair compared equal this run.
- TIMEOUT_ERR  out  1  sticky: a measurement exceeded MAX_WAIT; run aborted.

## Operation
- States: IDLE, CLR, SETTLE, MEAS, CAPT, CMP, FIN.
- IDLE: START=1 latches SEED_CHAL, clears bit index i, meas flag m, RESPONSE, VALID, TIE_SEEN, TIMEOUT_ERR; -> CLR.
- Challenge for bit i: low 6 bits = (SEED_CHAL + i) mod 64 (wraps); muxSel = {i[0], m}. Even bits compare RO0 vs RO1, odd bits RO2 vs RO3; m=0 is measurement A, m=1 is B.
- CLR (1 cycle): PUF_RST=1, PUF_EN=0 -> SETTLE.
- SETTLE (2 cycles): PUF_RST=0, PUF_EN=0, challenge stable -> MEAS.
- MEAS: PUF_EN=1, wait counter increments each cycle. PUF_DONE=1 -> CAPT. Wait counter reaching MAX_WAIT with DONE low -> set TIMEOUT_ERR, -> FIN.
- CAPT (1 cycle): PUF_EN=0; register PUF_COUNT into cntA (m=0) or cntB (m=1). m=0: set m=1, -> CLR. m=1: -> CMP.
- CMP (1 cycle): RESPONSE[i] = (cntA > cntB), unsigned, full COUNT_W compare. cntA == cntB -> bit 0, TIE_SEEN=1. i == N_BITS-1 -> FIN, else i++, m=0, -> CLR.
- FIN (1 cycle): VALID = ~TIMEOUT_ERR, BUSY=0 -> IDLE.
- START while not IDLE: ignored. RESPONSE/VALID/flags hold in IDLE until next accepted START.
- PUF_DONE ignored outside MEAS.

## Timing
- Reset (RST=0, asynchronous): state IDLE; PUF_EN=0, PUF_RST=0, PUF_CHALLENGE=0, BUSY=0, VALID=0, RESPONSE=0, TIE_SEEN=0, TIMEOUT_ERR=0, internal counters 0. Reset mid-run aborts immediately with these values; release is sampled on the next clk edge.
- All outputs registered; no combinational input-to-output paths.
- BUSY rises the cycle after START is sampled and falls the cycle VALID rises.
- Per measurement: 1 (CLR) + 2 (SETTLE) + W (MEAS, W = cycles until DONE seen) + 1 (CAPT). Per bit: two measurements + 1 (CMP). Total run: N_BITS*(2*(4+W)+1) + 1 (FIN) cycles after START.
- PUF_CHALLENGE changes only on entry to CLR; it is stable throughout SETTLE/MEAS/CAPT.
- PUF_EN is never high in the same cycle as PUF_RST.
- Wait counter clears on MEAS entry; timeout fires on the cycle count == MAX_WAIT.

## Test plan
- Single bit, N_BITS=1, PUF model returning A=100, B=50 with DONE after 10 cycles -> RESPONSE=1'b1, VALID=1, TIE_SEEN=0, run length 2*(4+10)+1+1 = 30 cycles.
- N_BITS=8, SEED_CHAL=6'h3E: check PUF_CHALLENGE low bits sequence 3E,3E,3F,3F,00,00,01,01,... (wrap) and muxSel sequence 0,1,2,3,0,1,2,3; model counts chosen so RESPONSE=8'hA5.
- Tie: A=B=777 for bit 2 -> RESPONSE[2]=0, TIE_SEEN=1, VALID=1.
- Timeout: MAX_WAIT=20, model never raises DONE -> TIMEOUT_ERR=1 at cycle 20 of MEAS, VALID=0, BUSY=0, PUF_EN=0.
- START pulses during BUSY and DONE pulses during CLR/SETTLE -> no effect on sequence or result; back-to-back START after FIN accepted and clears VALID.
- RST=0 asserted mid-MEAS -> all outputs 0 asynchronously (before next clk edge); after release, new START completes a correct run.
